// File: rtl/spi_slave_regbank.sv
// SPI mode-0 slave exposing four RW and four RO 32-bit registers to fabric logic.
// SPI pins are oversampled in the clk_clk domain; one 40-bit frame = command byte + 32 data bits.
module spi_slave_regbank #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  SIGNATURE   = 8'hA5,
  parameter logic [31:0] RST_VAL     = 32'h0000_0000
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic         spi_sclk,
  input  logic         spi_mosi,
  input  logic         spi_ss_n,
  output logic         spi_miso,
  output logic [127:0] rw_regs,
  input  logic [127:0] ro_regs,
  output logic [3:0]   wr_strobe,
  output logic         frame_done,
  output logic         frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic [SYNC_STAGES-1:0] r_ssSync;
  logic                   r_sclkPrev;
  logic                   r_ssPrev;

  logic [5:0]        r_bitCnt;
  logic [31:0]       r_rxShift;
  logic [31:0]       r_txShift;
  logic              r_rw;
  logic [2:0]        r_addr;
  logic              r_miso;
  logic [3:0][31:0]  r_rwRegs;
  logic [3:0]        r_wrStrobe;
  logic              r_frameDone;
  logic              r_frameErr;

  logic        w_sclk;
  logic        w_mosi;
  logic        w_ss;
  logic        w_sclkRise;
  logic        w_sclkFall;
  logic        w_ssFall;
  logic        w_ssRise;
  logic        w_abort;
  logic [2:0]  w_cmdAddr;
  logic [31:0] w_readData;

  // SS_n synchronisers reset high so an idle bus never looks like a frame start.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sclkSync <= '0;
      r_mosiSync <= '0;
      r_ssSync   <= '1;
      r_sclkPrev <= 1'b0;
      r_ssPrev   <= 1'b1;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_sclk};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], spi_ss_n};
      r_sclkPrev <= w_sclk;
      r_ssPrev   <= w_ss;
    end
  end

  assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
  assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
  assign w_ss       = r_ssSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclk & ~r_sclkPrev;
  assign w_sclkFall = ~w_sclk & r_sclkPrev;
  assign w_ssFall   = ~w_ss & r_ssPrev;
  assign w_ssRise   = w_ss & ~r_ssPrev;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The 40th SCLK rise outranks an SS_n rise seen in the same cycle; WAIT then exits on the SS_n level.
  always_comb begin
    w_nextState = r_state;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ssFall) begin
          w_nextState = S_CMD;
        end
      end
      S_CMD: begin
        if (w_ssRise) begin
          w_nextState = S_IDLE;
          w_abort     = 1'b1;
        end else if (w_sclkRise && (r_bitCnt == 6'd7)) begin
          w_nextState = S_DATA;
        end
      end
      S_DATA: begin
        if (w_sclkRise && (r_bitCnt == 6'd39)) begin
          w_nextState = S_DONE;
        end else if (w_ssRise) begin
          w_nextState = S_IDLE;
          w_abort     = 1'b1;
        end
      end
      S_DONE: begin
        w_nextState = S_WAIT;
      end
      S_WAIT: begin
        if (w_ss) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // The address completes with the MOSI bit arriving on the 8th rise, so decode it from the live shifter.
  always_comb begin
    w_cmdAddr  = {r_rxShift[1:0], w_mosi};
    w_readData = '0;
    if (!w_cmdAddr[2]) begin
      w_readData = r_rwRegs[w_cmdAddr[1:0]];
    end else begin
      w_readData = ro_regs[{w_cmdAddr[1:0], 5'd0} +: 32];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_bitCnt    <= '0;
      r_rxShift   <= '0;
      r_txShift   <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_miso      <= 1'b0;
      r_rwRegs    <= {4{RST_VAL}};
      r_wrStrobe  <= '0;
      r_frameDone <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_wrStrobe  <= '0;
      r_frameDone <= 1'b0;
      r_frameErr  <= w_abort;
      case (r_state)
        S_IDLE: begin
          r_bitCnt <= '0;
          if (w_ssFall) begin
            r_miso    <= SIGNATURE[7];
            r_txShift <= {SIGNATURE[6:0], 25'd0};
          end else begin
            r_miso <= 1'b0;
          end
        end
        S_CMD, S_DATA: begin
          if (w_sclkRise) begin
            r_rxShift <= {r_rxShift[30:0], w_mosi};
            r_bitCnt  <= r_bitCnt + 6'd1;
            if ((r_state == S_CMD) && (r_bitCnt == 6'd7)) begin
              r_rw      <= r_rxShift[6];
              r_addr    <= w_cmdAddr;
              r_txShift <= w_readData;
            end
          end
          if (w_sclkFall) begin
            r_miso    <= r_txShift[31];
            r_txShift <= {r_txShift[30:0], 1'b0};
          end
          if (w_abort) begin
            r_miso <= 1'b0;
          end
        end
        S_DONE: begin
          r_frameDone <= 1'b1;
          if (r_rw && !r_addr[2]) begin
            r_rwRegs[r_addr[1:0]]   <= r_rxShift;
            r_wrStrobe[r_addr[1:0]] <= 1'b1;
          end
          if (w_sclkFall) begin
            r_miso <= 1'b0;
          end
        end
        S_WAIT: begin
          if (w_sclkFall || w_ss) begin
            r_miso <= 1'b0;
          end
        end
        default: begin
          r_miso <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso   = r_miso;
  assign rw_regs    = r_rwRegs;
  assign wr_strobe  = r_wrStrobe;
  assign frame_done = r_frameDone;
  assign frame_err  = r_frameErr;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed self-checking bench for spi_slave_regbank: acts as a mode-0 SPI master at SCLK = clk/8.
module tb_spi_slave_regbank;

  logic         clk_clk = 1'b0;
  logic         reset_reset_n;
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_ss_n;
  logic         spi_miso;
  logic [127:0] rw_regs;
  logic [127:0] ro_regs;
  logic [3:0]   wr_strobe;
  logic         frame_done;
  logic         frame_err;

  int checks = 0;
  int errors = 0;

  int          strobeCnt [4];
  logic [31:0] lastStrobeVal [4];
  int          doneCnt = 0;
  int          errCnt = 0;

  int baseStrobe [4];
  int baseDone;
  int baseErr;

  logic [3:0][31:0] expRegs;
  logic [39:0]      rx;

  spi_slave_regbank dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_ss_n      (spi_ss_n),
    .spi_miso      (spi_miso),
    .rw_regs       (rw_regs),
    .ro_regs       (ro_regs),
    .wr_strobe     (wr_strobe),
    .frame_done    (frame_done),
    .frame_err     (frame_err)
  );

  always #5 clk_clk = ~clk_clk;

  // Pulse monitor: counts high cycles of every strobe and captures the register seen alongside each strobe.
  initial begin
    for (int k = 0; k < 4; k++) begin
      strobeCnt[k]     = 0;
      lastStrobeVal[k] = '0;
    end
  end

  always @(negedge clk_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_strobe[k] === 1'b1) begin
        strobeCnt[k]     = strobeCnt[k] + 1;
        lastStrobeVal[k] = rw_regs[k*32 +: 32];
      end
    end
    if (frame_done === 1'b1) doneCnt = doneCnt + 1;
    if (frame_err === 1'b1) errCnt = errCnt + 1;
  end

  task automatic snapshot();
    for (int k = 0; k < 4; k++) baseStrobe[k] = strobeCnt[k];
    baseDone = doneCnt;
    baseErr  = errCnt;
  endtask

  // Master transfer: MOSI set after each fall, MISO sampled just before each rise.
  task automatic spiXfer(input logic [39:0] txBits, input int nBits, input bit raiseSs,
                         output logic [39:0] rxBits);
    rxBits = '0;
    @(negedge clk_clk);
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk_clk);
    for (int i = 0; i < nBits; i++) begin
      spi_mosi = txBits[39-i];
      repeat (4) @(negedge clk_clk);
      rxBits[39-i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk_clk);
      spi_sclk = 1'b0;
    end
    if (raiseSs) begin
      repeat (4) @(negedge clk_clk);
      spi_ss_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (8) @(negedge clk_clk);
    end
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_ss_n = 1'b1;
    ro_regs  = {32'hDEADBEEF, 32'h0BADF00D, 32'hCAFE0005, 32'h44444444};
    #2 reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);
    expRegs = '0;
    checks++; if (rw_regs !== 128'h0) begin errors++; $display("[TB] FAIL reset_rw_regs: got %h expected %h", rw_regs, 128'h0); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b expected 0", spi_miso); end
    checks++; if (wr_strobe !== 4'b0) begin errors++; $display("[TB] FAIL reset_strobe: got %b expected 0000", wr_strobe); end
    checks++; if ({frame_done, frame_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 00", {frame_done, frame_err}); end
  endtask

  task automatic test_write();
    snapshot();
    spiXfer({8'h81, 32'h12345678}, 40, 1'b1, rx);
    expRegs[1] = 32'h12345678;
    checks++; if (rx[39:32] !== 8'hA5) begin errors++; $display("[TB] FAIL write_signature: got %h expected a5", rx[39:32]); end
    checks++; if (rw_regs[63:32] !== 32'h12345678) begin errors++; $display("[TB] FAIL write_reg1: got %h expected 12345678", rw_regs[63:32]); end
    checks++; if (rw_regs !== expRegs) begin errors++; $display("[TB] FAIL write_all_regs: got %h expected %h", rw_regs, expRegs); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (strobeCnt[k] - baseStrobe[k] !== ((k == 1) ? 1 : 0)) begin
        errors++; $display("[TB] FAIL write_strobe%0d: got %0d cycles expected %0d", k, strobeCnt[k] - baseStrobe[k], (k == 1) ? 1 : 0);
      end
    end
    checks++; if (lastStrobeVal[1] !== 32'h12345678) begin errors++; $display("[TB] FAIL write_strobe_alignment: got %h expected 12345678", lastStrobeVal[1]); end
    checks++; if (doneCnt - baseDone !== 1) begin errors++; $display("[TB] FAIL write_frame_done: got %0d expected 1", doneCnt - baseDone); end
    checks++; if (errCnt - baseErr !== 0) begin errors++; $display("[TB] FAIL write_frame_err: got %0d expected 0", errCnt - baseErr); end
  endtask

  task automatic test_read();
    snapshot();
    spiXfer({8'h01, 32'h0}, 40, 1'b1, rx);
    checks++; if (rx[39:32] !== 8'hA5) begin errors++; $display("[TB] FAIL read_signature: got %h expected a5", rx[39:32]); end
    checks++; if (rx[31:0] !== 32'h12345678) begin errors++; $display("[TB] FAIL read_reg1: got %h expected 12345678", rx[31:0]); end
    checks++; if (rw_regs !== expRegs) begin errors++; $display("[TB] FAIL read_regs_unchanged: got %h expected %h", rw_regs, expRegs); end
    checks++; if (doneCnt - baseDone !== 1) begin errors++; $display("[TB] FAIL read_frame_done: got %0d expected 1", doneCnt - baseDone); end
    spiXfer({8'h79, 32'hFFFFFFFF}, 40, 1'b1, rx);
    checks++; if (rx[31:0] !== 32'h12345678) begin errors++; $display("[TB] FAIL read_dont_care_bits: got %h expected 12345678", rx[31:0]); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (strobeCnt[k] - baseStrobe[k] !== 0) begin
        errors++; $display("[TB] FAIL read_strobe%0d: got %0d expected 0", k, strobeCnt[k] - baseStrobe[k]);
      end
    end
  endtask

  task automatic test_ro_regs();
    snapshot();
    spiXfer({8'h07, 32'h0}, 40, 1'b1, rx);
    checks++; if (rx[31:0] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ro_read_addr7: got %h expected deadbeef", rx[31:0]); end
    spiXfer({8'h04, 32'h0}, 40, 1'b1, rx);
    checks++; if (rx[31:0] !== 32'h44444444) begin errors++; $display("[TB] FAIL ro_read_addr4: got %h expected 44444444", rx[31:0]); end
    spiXfer({8'h87, 32'h11111111}, 40, 1'b1, rx);
    checks++; if (rw_regs !== expRegs) begin errors++; $display("[TB] FAIL ro_write_ignored: got %h expected %h", rw_regs, expRegs); end
    checks++; if (wr_strobe !== 4'b0 || strobeCnt[0] + strobeCnt[1] + strobeCnt[2] + strobeCnt[3] !== baseStrobe[0] + baseStrobe[1] + baseStrobe[2] + baseStrobe[3]) begin
      errors++; $display("[TB] FAIL ro_write_strobe: got %0d strobe cycles expected 0", strobeCnt[0] + strobeCnt[1] + strobeCnt[2] + strobeCnt[3] - baseStrobe[0] - baseStrobe[1] - baseStrobe[2] - baseStrobe[3]);
    end
    checks++; if (doneCnt - baseDone !== 3) begin errors++; $display("[TB] FAIL ro_frame_done: got %0d expected 3", doneCnt - baseDone); end
  endtask

  task automatic test_abort();
    snapshot();
    spiXfer({8'h82, 32'h55AA55AA}, 20, 1'b1, rx);
    checks++; if (rw_regs[95:64] !== 32'h0) begin errors++; $display("[TB] FAIL abort_reg2: got %h expected 00000000", rw_regs[95:64]); end
    checks++; if (errCnt - baseErr !== 1) begin errors++; $display("[TB] FAIL abort_frame_err: got %0d expected 1", errCnt - baseErr); end
    checks++; if (doneCnt - baseDone !== 0) begin errors++; $display("[TB] FAIL abort_frame_done: got %0d expected 0", doneCnt - baseDone); end
    checks++; if (strobeCnt[2] - baseStrobe[2] !== 0) begin errors++; $display("[TB] FAIL abort_strobe: got %0d expected 0", strobeCnt[2] - baseStrobe[2]); end
    snapshot();
    spiXfer({8'h82, 32'hA5A50F0F}, 40, 1'b1, rx);
    expRegs[2] = 32'hA5A50F0F;
    checks++; if (rw_regs !== expRegs) begin errors++; $display("[TB] FAIL abort_recover_regs: got %h expected %h", rw_regs, expRegs); end
    checks++; if (strobeCnt[2] - baseStrobe[2] !== 1) begin errors++; $display("[TB] FAIL abort_recover_strobe: got %0d expected 1", strobeCnt[2] - baseStrobe[2]); end
    checks++; if (errCnt - baseErr !== 0) begin errors++; $display("[TB] FAIL abort_recover_err: got %0d expected 0", errCnt - baseErr); end
  endtask

  task automatic test_reset_midframe();
    snapshot();
    spiXfer({8'h80, 32'hFFFFFFFF}, 30, 1'b0, rx);
    reset_reset_n = 1'b0;
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    #1;
    expRegs = '0;
    checks++; if (rw_regs !== 128'h0) begin errors++; $display("[TB] FAIL midreset_regs: got %h expected 0", rw_regs); end
    checks++; if ({spi_miso, wr_strobe, frame_done, frame_err} !== 7'b0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %b expected 0000000", {spi_miso, wr_strobe, frame_done, frame_err});
    end
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);
    checks++; if (strobeCnt[0] - baseStrobe[0] !== 0) begin errors++; $display("[TB] FAIL midreset_no_strobe: got %0d expected 0", strobeCnt[0] - baseStrobe[0]); end
    spiXfer({8'h80, 32'h0000ABCD}, 40, 1'b1, rx);
    expRegs[0] = 32'h0000ABCD;
    checks++; if (rw_regs !== expRegs) begin errors++; $display("[TB] FAIL midreset_rewrite: got %h expected %h", rw_regs, expRegs); end
    checks++; if (strobeCnt[0] - baseStrobe[0] !== 1) begin errors++; $display("[TB] FAIL midreset_rewrite_strobe: got %0d expected 1", strobeCnt[0] - baseStrobe[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'h01020304;
    vals[1] = 32'hA0B0C0D0;
    vals[2] = 32'hFFFF0000;
    vals[3] = 32'h80000001;
    snapshot();
    for (int a = 0; a < 4; a++) begin
      spiXfer({8'h80 | 8'(a), vals[a]}, 40, 1'b1, rx);
      expRegs[a] = vals[a];
    end
    for (int a = 0; a < 4; a++) begin
      spiXfer({8'(a), 32'h0}, 40, 1'b1, rx);
      checks++;
      if (rx[31:0] !== vals[a]) begin
        errors++; $display("[TB] FAIL b2b_read%0d: got %h expected %h", a, rx[31:0], vals[a]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (strobeCnt[k] - baseStrobe[k] !== 1 || lastStrobeVal[k] !== vals[k]) begin
        errors++; $display("[TB] FAIL b2b_strobe%0d: got %0d cycles value %h expected 1 cycle value %h", k, strobeCnt[k] - baseStrobe[k], lastStrobeVal[k], vals[k]);
      end
    end
    checks++; if (rw_regs !== expRegs) begin errors++; $display("[TB] FAIL b2b_regs: got %h expected %h", rw_regs, expRegs); end
    checks++; if (doneCnt - baseDone !== 8) begin errors++; $display("[TB] FAIL b2b_frame_done: got %0d expected 8", doneCnt - baseDone); end
    checks++; if (errCnt - baseErr !== 0) begin errors++; $display("[TB] FAIL b2b_frame_err: got %0d expected 0", errCnt - baseErr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ro_regs();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
